// File: rtl/cam_power_seq_pkg.sv
// ============================================================================
// Module : cam_pwr_pkg
// Brief  : State encoding and timing helpers for the camera power sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cam_pwr_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PWDN_WAIT = 3'd1,
        ST_RST_WAIT  = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_READY     = 3'd4,
        ST_SHUTDOWN  = 3'd5
    } state_t;

    // A zero-length phase still occupies one cycle so every timed state is visible.
    function automatic int us_to_cycles(input int freq, input int us);
        int n;
        n = (freq / 1_000_000) * us;
        return (n < 1) ? 1 : n;
    endfunction

    function automatic logic is_timed(input state_t s);
        return (s == ST_PWDN_WAIT) || (s == ST_RST_WAIT) ||
               (s == ST_SETTLE)    || (s == ST_SHUTDOWN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cam_power_seq_pwr_phase_timer.sv
// ============================================================================
// Module : pwr_phase_timer
// Brief  : Phase up-counter with clear, enable and terminal-count flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwr_phase_timer #(
    parameter int CW = 8
) (
    input  logic          sysclk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [CW-1:0] limit_i,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == limit_i);

endmodule

`default_nettype wire

// File: rtl/cam_power_seq.sv
// ============================================================================
// Module : cam_power_seq
// Brief  : Timed PWDN/RESET power-up and power-down sequencer for CMOS sensors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cam_power_seq
    import cam_pwr_pkg::*;
#(
    parameter int   CLK_FREQ_HZ = 50_000_000,
    parameter int   T_PWDN_US   = 5000,
    parameter int   T_RESET_US  = 2000,
    parameter int   T_SETTLE_US = 21000,
    parameter int   T_OFF_US    = 1000,
    parameter logic PWDN_ACTIVE = 1'b1
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       pwr_req,
    input  logic       restart,
    output logic       coms_pwdn,
    output logic       coms_reset,
    output logic       done,
    output logic       busy,
    output logic [2:0] state
);

    localparam int N_PWDN   = us_to_cycles(CLK_FREQ_HZ, T_PWDN_US);
    localparam int N_RESET  = us_to_cycles(CLK_FREQ_HZ, T_RESET_US);
    localparam int N_SETTLE = us_to_cycles(CLK_FREQ_HZ, T_SETTLE_US);
    localparam int N_OFF    = us_to_cycles(CLK_FREQ_HZ, T_OFF_US);
    localparam int N_MAX_A  = (N_PWDN > N_RESET) ? N_PWDN : N_RESET;
    localparam int N_MAX_B  = (N_SETTLE > N_OFF) ? N_SETTLE : N_OFF;
    localparam int N_MAX    = (N_MAX_A > N_MAX_B) ? N_MAX_A : N_MAX_B;
    localparam int CW       = $clog2(N_MAX) + 1;

    localparam logic [CW-1:0] LIM_PWDN   = CW'(N_PWDN - 1);
    localparam logic [CW-1:0] LIM_RESET  = CW'(N_RESET - 1);
    localparam logic [CW-1:0] LIM_SETTLE = CW'(N_SETTLE - 1);
    localparam logic [CW-1:0] LIM_OFF    = CW'(N_OFF - 1);

    state_t        state_q;
    state_t        state_d;
    logic          pending_q;
    logic          pending_d;
    logic [CW-1:0] limit;
    logic          tmr_tc;

    always_comb begin
        limit = '0;
        case (state_q)
            ST_PWDN_WAIT: limit = LIM_PWDN;
            ST_RST_WAIT:  limit = LIM_RESET;
            ST_SETTLE:    limit = LIM_SETTLE;
            ST_SHUTDOWN:  limit = LIM_OFF;
            default:      limit = '0;
        endcase
    end

    pwr_phase_timer #(
        .CW (CW)
    ) u_timer (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .clr_i   (state_d != state_q),
        .en_i    (is_timed(state_q)),
        .limit_i (limit),
        .tc_o    (tmr_tc)
    );

    // Once the sensor is out of power-down it must always leave via SHUTDOWN.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (restart)
            pending_d = 1'b1;
        else if (state_q == ST_OFF)
            pending_d = 1'b0;

        case (state_q)
            ST_OFF:
                if (pwr_req && !pending_q && !restart)
                    state_d = ST_PWDN_WAIT;
            ST_PWDN_WAIT:
                if (!pwr_req || restart) state_d = ST_OFF;
                else if (tmr_tc)         state_d = ST_RST_WAIT;
            ST_RST_WAIT:
                if (!pwr_req || restart) state_d = ST_SHUTDOWN;
                else if (tmr_tc)         state_d = ST_SETTLE;
            ST_SETTLE:
                if (!pwr_req || restart) state_d = ST_SHUTDOWN;
                else if (tmr_tc)         state_d = ST_READY;
            ST_READY:
                if (!pwr_req || restart) state_d = ST_SHUTDOWN;
            ST_SHUTDOWN:
                if (tmr_tc) state_d = ST_OFF;
            default:
                state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            pending_q  <= 1'b0;
            coms_pwdn  <= PWDN_ACTIVE;
            coms_reset <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            coms_pwdn  <= ((state_d == ST_OFF) || (state_d == ST_PWDN_WAIT))
                          ? PWDN_ACTIVE : ~PWDN_ACTIVE;
            coms_reset <= (state_d == ST_SETTLE) || (state_d == ST_READY);
            done       <= (state_d == ST_READY);
            busy       <= is_timed(state_d);
        end
    end

    assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_power_seq.sv
// ============================================================================
// Module : tb_cam_power_seq
// Brief  : Directed self-checking bench for the camera power sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cam_power_seq;

    localparam logic [2:0] S_OFF = 3'd0;
    localparam logic [2:0] S_PW  = 3'd1;
    localparam logic [2:0] S_RW  = 3'd2;
    localparam logic [2:0] S_SE  = 3'd3;
    localparam logic [2:0] S_RD  = 3'd4;
    localparam logic [2:0] S_SD  = 3'd5;

    logic       sysclk;
    logic       rst_n;
    logic       pwr_req;
    logic       restart;
    logic       coms_pwdn, coms_reset, done, busy;
    logic [2:0] state;
    logic       pwdn2, reset2, done2, busy2;
    logic [2:0] state2;

    int checks;
    int failures;

    cam_power_seq #(
        .CLK_FREQ_HZ (1_000_000), .T_PWDN_US (5), .T_RESET_US (2),
        .T_SETTLE_US (21), .T_OFF_US (3), .PWDN_ACTIVE (1'b1)
    ) dut (
        .sysclk (sysclk), .rst_n (rst_n), .pwr_req (pwr_req), .restart (restart),
        .coms_pwdn (coms_pwdn), .coms_reset (coms_reset), .done (done),
        .busy (busy), .state (state)
    );

    cam_power_seq #(
        .CLK_FREQ_HZ (1_000_000), .T_PWDN_US (5), .T_RESET_US (0),
        .T_SETTLE_US (21), .T_OFF_US (3), .PWDN_ACTIVE (1'b0)
    ) dut2 (
        .sysclk (sysclk), .rst_n (rst_n), .pwr_req (pwr_req), .restart (restart),
        .coms_pwdn (pwdn2), .coms_reset (reset2), .done (done2),
        .busy (busy2), .state (state2)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Pin levels {pwdn, reset, done, busy} the sensor should see in a given state.
    function automatic logic [3:0] exp_pins(input logic [2:0] s, input logic act);
        logic p;
        p = ((s == S_OFF) || (s == S_PW)) ? act : ~act;
        return {p, (s == S_SE) || (s == S_RD), (s == S_RD),
                (s == S_PW) || (s == S_RW) || (s == S_SE) || (s == S_SD)};
    endfunction

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string tag);
        int n;
        n = 0;
        while (state !== s && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (state !== s) begin
            failures++;
            $display("FAIL %s_timeout state=%0d required=%0d", tag, state, s);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; pwr_req = 1'b0; restart = 1'b0;
        #1 rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({state, coms_pwdn, coms_reset, done, busy} !== {S_OFF, 4'b1000}) begin
            failures++;
            $display("FAIL reset_dut1 got=%b required=%b",
                     {state, coms_pwdn, coms_reset, done, busy}, {S_OFF, 4'b1000});
        end
        checks++;
        if ({state2, pwdn2, reset2, done2, busy2} !== {S_OFF, 4'b0000}) begin
            failures++;
            $display("FAIL reset_dut2 got=%b required=%b",
                     {state2, pwdn2, reset2, done2, busy2}, {S_OFF, 4'b0000});
        end
    endtask

    task automatic test_powerup();
        logic [6:0] exp;
        logic [2:0] es;
        rst_n = 1'b0; pwr_req = 1'b1; restart = 1'b0;
        #2 rst_n = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            es  = (e <= 5) ? S_PW : (e <= 7) ? S_RW : (e <= 28) ? S_SE : S_RD;
            exp = {es, exp_pins(es, 1'b1)};
            checks++;
            if ({state, coms_pwdn, coms_reset, done, busy} !== exp) begin
                failures++;
                $display("FAIL powerup edge=%0d got=%b required=%b", e,
                         {state, coms_pwdn, coms_reset, done, busy}, exp);
            end
        end
    endtask

    task automatic test_powerdown();
        logic [6:0] exp;
        logic [2:0] es;
        pwr_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            es  = (k <= 3) ? S_SD : S_OFF;
            exp = {es, exp_pins(es, 1'b1)};
            checks++;
            if ({state, coms_pwdn, coms_reset, done, busy} !== exp) begin
                failures++;
                $display("FAIL powerdown k=%0d got=%b required=%b", k,
                         {state, coms_pwdn, coms_reset, done, busy}, exp);
            end
        end
    endtask

    task automatic test_restart();
        logic [6:0] exp;
        logic [2:0] es;
        pwr_req = 1'b1;
        wait_state(S_RD, 40, "restart_ready");
        restart = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            tick();
            restart = 1'b0;
            es = (k <= 3) ? S_SD : (k <= 5) ? S_OFF : (k <= 10) ? S_PW :
                 (k <= 12) ? S_RW : (k <= 33) ? S_SE : S_RD;
            exp = {es, exp_pins(es, 1'b1)};
            checks++;
            if ({state, coms_pwdn, coms_reset, done, busy} !== exp) begin
                failures++;
                $display("FAIL restart k=%0d got=%b required=%b", k,
                         {state, coms_pwdn, coms_reset, done, busy}, exp);
            end
        end
    endtask

    task automatic test_drop_pwdn_wait();
        pwr_req = 1'b0;
        wait_state(S_OFF, 10, "drop_pw_off");
        pwr_req = 1'b1;
        tick(); tick();
        checks++;
        if ({state, coms_pwdn} !== {S_PW, 1'b1}) begin
            failures++;
            $display("FAIL drop_pw_entry got=%b required=%b", {state, coms_pwdn}, {S_PW, 1'b1});
        end
        pwr_req = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if ({state, coms_pwdn, coms_reset, done, busy} !== {S_OFF, 4'b1000}) begin
                failures++;
                $display("FAIL drop_pw k=%0d got=%b required=%b", k,
                         {state, coms_pwdn, coms_reset, done, busy}, {S_OFF, 4'b1000});
            end
        end
    endtask

    task automatic test_drop_settle();
        logic [2:0] es;
        pwr_req = 1'b1;
        wait_state(S_SE, 20, "drop_se_settle");
        tick(); tick();
        pwr_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            es = (k <= 3) ? S_SD : S_OFF;
            checks++;
            if ({state, coms_pwdn, coms_reset, done, busy} !== {es, exp_pins(es, 1'b1)}) begin
                failures++;
                $display("FAIL drop_se k=%0d got=%b required=%b", k,
                         {state, coms_pwdn, coms_reset, done, busy}, {es, exp_pins(es, 1'b1)});
            end
        end
    endtask

    task automatic test_async_reset();
        pwr_req = 1'b1;
        wait_state(S_SE, 20, "async_settle");
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({state, coms_pwdn, coms_reset, done, busy} !== {S_OFF, 4'b1000}) begin
            failures++;
            $display("FAIL async_reset got=%b required=%b",
                     {state, coms_pwdn, coms_reset, done, busy}, {S_OFF, 4'b1000});
        end
        test_powerup();
    endtask

    task automatic test_param2();
        logic [2:0] es;
        rst_n = 1'b0; pwr_req = 1'b1; restart = 1'b0;
        #2;
        checks++;
        if (pwdn2 !== 1'b0) begin
            failures++;
            $display("FAIL p2_reset_pwdn got=%b required=0", pwdn2);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            es = (e <= 5) ? S_PW : (e == 6) ? S_RW : S_SE;
            checks++;
            if ({state2, pwdn2, reset2, done2, busy2} !== {es, exp_pins(es, 1'b0)}) begin
                failures++;
                $display("FAIL p2 edge=%0d got=%b required=%b", e,
                         {state2, pwdn2, reset2, done2, busy2}, {es, exp_pins(es, 1'b0)});
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_powerup();
        test_powerdown();
        test_restart();
        test_drop_pwdn_wait();
        test_drop_settle();
        test_async_reset();
        test_param2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
